// File: rtl/encoder_prio_pkg.sv
// Shared helpers for the priority encoder: index width and multi-hit detection.
package encoder_prio_pkg;

  // Widest request vector the helpers are sized for.
  localparam int unsigned MaxInW = 64;

  // Index width for an n-bit request vector; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // True when two or more bits are set: clearing the lowest set bit leaves something behind.
  function automatic logic popcount_ge2(input logic [MaxInW-1:0] v);
    return (v & (v - MaxInW'(1))) != '0;
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational priority encoder: index of the highest set bit plus an any-hit flag.
module prio_enc_core #(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = 2
) (
  input  logic [IN_W-1:0]  d,
  output logic [OUT_W-1:0] idx,
  output logic             any
);

  // Scan LSB to MSB so the highest set bit is the last to write idx.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (d[i]) begin
        idx = OUT_W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/encoder_prio.sv
// Registered priority encoder: captures index, valid and multi-hit flags when enabled.
module encoder_prio
  import encoder_prio_pkg::*;
#(
  parameter int unsigned IN_W  = 4,
  parameter int unsigned OUT_W = idx_width(IN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [IN_W-1:0]  d,
  output logic [OUT_W-1:0] y,
  output logic             valid,
  output logic             multi
);

  logic [OUT_W-1:0]  idx;
  logic              any;
  logic              many;
  logic [MaxInW-1:0] d_ext;

  logic [OUT_W-1:0] y_d, y_q;
  logic             valid_d, valid_q;
  logic             multi_d, multi_q;

  prio_enc_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .d   (d),
    .idx (idx),
    .any (any)
  );

  // Zero-extend the request vector so the shared helper handles any legal width.
  always_comb begin
    d_ext           = '0;
    d_ext[IN_W-1:0] = d;
    many            = popcount_ge2(d_ext);
  end

  // Next state: load the fresh encoding when enabled, otherwise hold.
  always_comb begin
    y_d     = y_q;
    valid_d = valid_q;
    multi_d = multi_q;
    if (en) begin
      y_d     = idx;
      valid_d = any;
      multi_d = many;
    end
  end

  // Output registers; reset wins over a pending capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

  assign y     = y_q;
  assign valid = valid_q;
  assign multi = multi_q;

endmodule

// File: tb/tb_encoder_prio.sv
// Directed bench for encoder_prio at IN_W=4 and IN_W=5.
module tb_encoder_prio;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] d4;
  logic [4:0] d5;
  logic [1:0] y4;
  logic [2:0] y5;
  logic       valid4, multi4, valid5, multi5;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  encoder_prio #(.IN_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (d4),
    .y     (y4),
    .valid (valid4),
    .multi (multi4)
  );

  encoder_prio #(.IN_W(5)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .d     (d5),
    .y     (y5),
    .valid (valid5),
    .multi (multi5)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic check4(input string tag, input logic [1:0] ey, input logic ev, input logic em);
    check({tag, ".y"},     8'(y4),     8'(ey));
    check({tag, ".valid"}, 8'(valid4), 8'(ev));
    check({tag, ".multi"}, 8'(multi4), 8'(em));
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: scan from MSB downward, count bits independently.
  task automatic model(input logic [7:0] v, input int w,
                       output logic [7:0] idx, output logic any, output logic many);
    int  cnt;
    logic found;
    cnt   = 0;
    found = 1'b0;
    idx   = 8'd0;
    for (int i = w - 1; i >= 0; i--) begin
      if (v[i]) begin
        cnt++;
        if (!found) begin
          idx   = 8'(i);
          found = 1'b1;
        end
      end
    end
    any  = (cnt > 0);
    many = (cnt >= 2);
  endtask

  initial begin
    logic [7:0] m_idx;
    logic       m_any, m_many;

    #1;
    // Reset held with a full request vector pending.
    rst_n = 1'b0; en = 1'b1; d4 = 4'b1111; d5 = 5'b0;
    tick(); check4("rst_cyc1", 2'd0, 1'b0, 1'b0);
    tick(); check4("rst_cyc2", 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1; check4("rst_release_pre_edge", 2'd0, 1'b0, 1'b0);
    tick(); check4("rst_first_capture", 2'd3, 1'b1, 1'b1);

    // Basic sweep; also confirm no combinational path before the edge.
    d4 = 4'b0000; #1; check4("no_comb_path", 2'd3, 1'b1, 1'b1);
    tick(); check4("sweep_0000", 2'd0, 1'b0, 1'b0);
    d4 = 4'b0001; tick(); check4("sweep_0001", 2'd0, 1'b1, 1'b0);
    d4 = 4'b0010; tick(); check4("sweep_0010", 2'd1, 1'b1, 1'b0);
    d4 = 4'b0011; tick(); check4("sweep_0011", 2'd1, 1'b1, 1'b1);

    // Priority: lower bits never influence the index.
    d4 = 4'b1000; tick(); check4("prio_1000", 2'd3, 1'b1, 1'b0);
    d4 = 4'b1010; tick(); check4("prio_1010", 2'd3, 1'b1, 1'b1);
    d4 = 4'b0110; tick(); check4("prio_0110", 2'd2, 1'b1, 1'b1);
    d4 = 4'b0100; tick(); check4("prio_0100", 2'd2, 1'b1, 1'b0);

    // Hold with en low, including X on d.
    en = 1'b0; d4 = 4'b0001; tick(); check4("hold_0001", 2'd2, 1'b1, 1'b0);
    d4 = 4'bxxxx; tick(); check4("hold_x1", 2'd2, 1'b1, 1'b0);
    tick(); check4("hold_x2", 2'd2, 1'b1, 1'b0);

    // Reset on the same edge as a capture.
    en = 1'b1; d4 = 4'b1000; rst_n = 1'b0;
    tick(); check4("rst_mid", 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick(); check4("rst_mid_after", 2'd3, 1'b1, 1'b0);

    // Exhaustive IN_W=4.
    for (int v = 0; v < 16; v++) begin
      d4 = 4'(v);
      tick();
      model(8'(v), 4, m_idx, m_any, m_many);
      check($sformatf("ex4_%0d.y", v),     8'(y4),     m_idx);
      check($sformatf("ex4_%0d.valid", v), 8'(valid4), 8'(m_any));
      check($sformatf("ex4_%0d.multi", v), 8'(multi4), 8'(m_many));
    end

    // Exhaustive IN_W=5; index must never exceed 4.
    for (int v = 0; v < 32; v++) begin
      d5 = 5'(v);
      tick();
      model(8'(v), 5, m_idx, m_any, m_many);
      check($sformatf("ex5_%0d.y", v),     8'(y5),     m_idx);
      check($sformatf("ex5_%0d.valid", v), 8'(valid5), 8'(m_any));
      check($sformatf("ex5_%0d.multi", v), 8'(multi5), 8'(m_many));
      check($sformatf("ex5_%0d.y_range", v), 8'(y5 <= 3'd4), 8'd1);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
